// File: rtl/fnd_scan_controller.sv
// Four-digit common-anode FND scan driver with blanking and frame-synchronous data updates.
// Optional macro FND_LZ_BLANK_EN enables leading-zero suppression on digits 3..1.
module fnd_scan_controller #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  seg_common,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [1:0]    digit;
  logic [1:0]    digit_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          boundary;

  logic [15:0]   act_bcd;
  logic [3:0]    act_dp;
  logic [15:0]   shd_bcd;
  logic [3:0]    shd_dp;
  logic          pending;

  logic [3:0]    nib;
  logic          dp_bit;
  logic [7:0]    seg_nx;
  logic [3:0]    com_nx;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      digit <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      digit <= digit_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    cnt_nx   = cnt;
    boundary = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      digit_nx = 2'd0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = BLANK;
          digit_nx = 2'd0;
          cnt_nx   = '0;
        end
        BLANK: begin
          cnt_nx = cnt + CW'(1);
          if (cnt == BLANK_LAST)
            state_nx = DRIVE;
        end
        DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nx   = '0;
            digit_nx = digit + 2'd1;
            state_nx = BLANK;
            boundary = (digit == 2'd3);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          digit_nx = 2'd0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Active data changes only while dark or at a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_bcd <= '0;
      act_dp  <= '0;
      shd_bcd <= '0;
      shd_dp  <= '0;
      pending <= 1'b0;
    end else if (load && (state == IDLE || boundary)) begin
      act_bcd <= bcd_in;
      act_dp  <= dp_in;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      act_bcd <= shd_bcd;
      act_dp  <= shd_dp;
      pending <= 1'b0;
    end else if (load) begin
      shd_bcd <= bcd_in;
      shd_dp  <= dp_in;
      pending <= 1'b1;
    end
  end

  assign nib    = act_bcd[{digit, 2'b00} +: 4];
  assign dp_bit = act_dp[digit];

`ifdef FND_LZ_BLANK_EN
  logic [3:0] sup;
  assign sup[3] = (act_bcd[15:12] == 4'h0);
  assign sup[2] = sup[3] && (act_bcd[11:8] == 4'h0);
  assign sup[1] = sup[2] && (act_bcd[7:4] == 4'h0);
  assign sup[0] = 1'b0;
`endif

  always_comb begin
    seg_nx = 8'hFF;
    com_nx = 4'hF;
    if (state == DRIVE) begin
      com_nx = ~(4'b0001 << digit);
      seg_nx = {~dp_bit, glyph(nib)};
`ifdef FND_LZ_BLANK_EN
      if (sup[digit]) begin
        if (dp_bit) begin
          seg_nx = 8'h7F;
        end else begin
          seg_nx = 8'hFF;
          com_nx = 4'hF;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg        <= 8'hFF;
      seg_common <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_nx;
      seg_common <= com_nx;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller at TICK_DIV=8, BLANK_CYC=2.
// Frames are checked sample by sample; expected glyphs are hand-written constants.
module tb_fnd_scan_controller;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  seg_common;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  fnd_scan_controller #(
    .TICK_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .seg       (seg),
    .seg_common(seg_common),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      bcd;
    logic [3:0]       dp;
    logic [3:0][7:0]  s;
    logic [3:0][3:0]  c;
  } rec_t;

  function automatic rec_t mk(input logic [15:0] b, input logic [3:0] d,
                              input logic [31:0] s, input logic [15:0] c);
    rec_t r;
    r.bcd = b;
    r.dp  = d;
    r.s   = s;
    r.c   = c;
    return r;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d got %h want %h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic chk_dark(input string nm);
    chk({nm, "_seg"}, 0, seg, 8'hFF);
    chk({nm, "_com"}, 0, {4'h0, seg_common}, 8'h0F);
    chk({nm, "_fd"}, 0, {7'h0, frame_done}, 8'h00);
  endtask

  // Starts right after the frame_done sample (or the IDLE-latency sample).
  task automatic check_frame(input rec_t e,
                             input int ia, input rec_t a,
                             input int ib, input rec_t b);
    for (int k = 1; k <= 32; k++) begin
      int sl;
      int ps;
      @(negedge clk);
      sl = (k - 1) / 8;
      ps = (k - 1) % 8;
      if (ps < 2) begin
        chk("seg_blank", k, seg, 8'hFF);
        chk("com_blank", k, {4'h0, seg_common}, 8'h0F);
      end else begin
        chk("seg_drive", k, seg, e.s[sl]);
        chk("com_drive", k, {4'h0, seg_common}, {4'h0, e.c[sl]});
      end
      chk("frame_done", k, {7'h0, frame_done}, {7'h0, 1'(k == 32)});
      chk("one_anode", k, {7'h0, 1'($countones(~seg_common) <= 1)}, 8'h01);
      if (k == ia) begin
        load = 1'b1; bcd_in = a.bcd; dp_in = a.dp;
      end else if (k == ib) begin
        load = 1'b1; bcd_in = b.bcd; dp_in = b.dp;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  localparam logic [15:0] CN = 16'h7BDE;

  rec_t r1234, rabcd, r8888, r0f0f, r0000, cur;
  rec_t tbl [4];

  initial begin
    r1234 = mk(16'h1234, 4'b0000, 32'hF9A4B099, CN);
    rabcd = mk(16'hABCD, 4'b0000, 32'h8883C6A1, CN);
    r8888 = mk(16'h8888, 4'b0100, 32'h80008080, CN);
    tbl[0] = r8888;
    tbl[2] = mk(16'h5069, 4'b1111, 32'h12400210, CN);
`ifdef FND_LZ_BLANK_EN
    r0f0f  = mk(16'h0F0F, 4'b0000, 32'hFF8EC08E, 16'hFBDE);
    r0000  = mk(16'h0000, 4'b0000, 32'hFFFFFFC0, 16'hFFFE);
    tbl[1] = mk(16'h0070, 4'b1000, 32'h7FFFF8C0, 16'h7FDE);
    tbl[3] = mk(16'h0007, 4'b0000, 32'hFFFFFFF8, 16'hFFFE);
`else
    r0f0f  = mk(16'h0F0F, 4'b0000, 32'hC08EC08E, CN);
    r0000  = mk(16'h0000, 4'b0000, 32'hC0C0C0C0, CN);
    tbl[1] = mk(16'h0070, 4'b1000, 32'h40C0F8C0, CN);
    tbl[3] = mk(16'h0007, 4'b0000, 32'hC0C0C0F8, CN);
`endif

    reset = 1'b1; enable = 1'b0; load = 1'b0;
    bcd_in = '0; dp_in = '0;
    repeat (3) @(negedge clk);
    chk_dark("reset");
    reset = 1'b0;

    load = 1'b1; bcd_in = 16'h1234; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    chk_dark("idle_load");
    enable = 1'b1;
    @(negedge clk);
    chk_dark("start");
    check_frame(r1234, 0, r1234, 0, r1234);

    check_frame(r1234, 12, rabcd, 0, rabcd);
    check_frame(rabcd, 0, rabcd, 0, rabcd);

    check_frame(rabcd, 5, r8888, 31, r0f0f);
    check_frame(r0f0f, 0, r0f0f, 0, r0f0f);
    check_frame(r0f0f, 0, r0f0f, 0, r0f0f);

    cur = r0f0f;
    for (int i = 0; i < 4; i++) begin
      check_frame(cur, 7, tbl[i], 0, tbl[i]);
      check_frame(tbl[i], 0, tbl[i], 0, tbl[i]);
      cur = tbl[i];
    end

    repeat (22) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_lit_com", 23, {4'h0, seg_common}, {4'h0, cur.c[2]});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk_dark("drop");
    end
    enable = 1'b1;
    @(negedge clk);
    chk_dark("reenable");
    check_frame(cur, 0, cur, 0, cur);

    repeat (5) @(negedge clk);
    reset = 1'b1; load = 1'b1; bcd_in = 16'h9999; dp_in = 4'hF;
    @(negedge clk);
    chk_dark("mid_reset");
    reset = 1'b0; load = 1'b0;
    @(negedge clk);
    chk_dark("post_reset");
    check_frame(r0000, 0, r0000, 0, r0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
